// File: rtl/rabbit_pkg.sv
// Shared types and defaults for the Rabbit serial frame path.
package rabbit_pkg;

  localparam int FRAME_BITS_DEF     = 184;
  localparam int TRIG_CYCLES_DEF    = 50;
  localparam int TIMEOUT_CYCLES_DEF = 500000;
  localparam int MAX_RETRY_DEF      = 3;

  localparam int RETRY_W  = 2;
  localparam int TIMER_W  = 19;
  localparam int BITCNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_CLK,
    ST_SHIFT,
    ST_CHECK,
    ST_RETRY
  } state_e;

endpackage

// File: rtl/rabbit_serial_sync.sv
// Two-flop synchronizers for the Rabbit SCLK/SDIO pads plus SCLK rise detect;
// SDIO is taken from the same stage so it lines up with the rise strobe.
module rabbit_serial_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sclk_i,
  input  logic sdio_i,
  output logic sclk_rise_o,
  output logic sdio_s_o
);

  logic sclk_meta_q, sclk_sync_q, sclk_dly_q;
  logic sdio_meta_q, sdio_sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_dly_q  <= 1'b0;
      sdio_meta_q <= 1'b0;
      sdio_sync_q <= 1'b0;
    end else begin
      sclk_meta_q <= sclk_i;
      sclk_sync_q <= sclk_meta_q;
      sclk_dly_q  <= sclk_sync_q;
      sdio_meta_q <= sdio_i;
      sdio_sync_q <= sdio_meta_q;
    end
  end

  assign sclk_rise_o = sclk_sync_q & ~sclk_dly_q;
  assign sdio_s_o    = sdio_sync_q;

endmodule

// File: rtl/rabbit_frame_sequencer.sv
// Triggers the Rabbit, captures one serial frame MSB-first with timeouts and retries.
// Optional even-parity acceptance check is enabled by defining RABBIT_PARITY_EN.
module rabbit_frame_sequencer
  import rabbit_pkg::*;
#(
  parameter int FRAME_BITS     = FRAME_BITS_DEF,
  parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int MAX_RETRY      = MAX_RETRY_DEF
) (
  input  logic                  fifty_MHz_int,
  input  logic                  reset_n,
  input  logic                  start_req,
  input  logic                  SCLK_PE_3,
  input  logic                  SDIO_PE_5,
  output logic                  trigger_out,
  output logic                  busy,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic                  frame_error,
  output logic [RETRY_W-1:0]    retry_count
);

  localparam logic [TIMER_W-1:0]  TRIG_LAST  = TIMER_W'(TRIG_CYCLES - 1);
  localparam logic [TIMER_W-1:0]  TMO_LAST   = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BITCNT_W-1:0] FRAME_LAST = BITCNT_W'(FRAME_BITS - 1);
  localparam logic [RETRY_W-1:0]  RETRY_MAX  = RETRY_W'(MAX_RETRY);

  state_e                state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d, timer_inc;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d, shift_in;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;
  logic                  sclk_rise, sdio_s;

  rabbit_serial_sync u_sync (
    .clk_i       (fifty_MHz_int),
    .rst_ni      (reset_n),
    .sclk_i      (SCLK_PE_3),
    .sdio_i      (SDIO_PE_5),
    .sclk_rise_o (sclk_rise),
    .sdio_s_o    (sdio_s)
  );

  assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;
  assign shift_in  = {shift_q[FRAME_BITS-2:0], sdio_s};

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_inc;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    frame_d  = frame_q;
    retry_d  = retry_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (start_req) begin
          state_d = ST_TRIG;
          retry_d = '0;
        end
      end
      ST_TRIG: begin
        // Rises during the trigger are dropped by keeping the shifter cleared.
        shift_d  = '0;
        bitcnt_d = '0;
        if (timer_q == TRIG_LAST) begin
          state_d = ST_WAIT_CLK;
          timer_d = '0;
        end
      end
      ST_WAIT_CLK: begin
        if (sclk_rise) begin
          shift_d  = shift_in;
          bitcnt_d = BITCNT_W'(1);
          timer_d  = '0;
          state_d  = ST_SHIFT;
        end else if (timer_q == TMO_LAST) begin
          state_d = ST_RETRY;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          shift_d  = shift_in;
          bitcnt_d = bitcnt_q + 1'b1;
          timer_d  = '0;
          if (bitcnt_q == FRAME_LAST) state_d = ST_CHECK;
        end else if (timer_q == TMO_LAST) begin
          state_d = ST_RETRY;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
`ifdef RABBIT_PARITY_EN
        if (^shift_q) begin
          state_d = ST_RETRY;
        end else begin
          frame_d = shift_q;
          valid_d = 1'b1;
        end
`else
        frame_d = shift_q;
        valid_d = 1'b1;
`endif
      end
      ST_RETRY: begin
        timer_d = '0;
        if (retry_q == RETRY_MAX) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          retry_d  = retry_q + 1'b1;
          shift_d  = '0;
          bitcnt_d = '0;
          state_d  = ST_TRIG;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge fifty_MHz_int or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      frame_q  <= '0;
      retry_q  <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      frame_q  <= frame_d;
      retry_q  <= retry_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign trigger_out = (state_q == ST_TRIG);
  assign busy        = (state_q != ST_IDLE);
  assign frame_data  = frame_q;
  assign frame_valid = valid_q;
  assign frame_error = error_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_rabbit_frame_sequencer.sv
// Scoreboard bench for rabbit_frame_sequencer with a per-request outcome model.
`timescale 1ns/1ps
module tb_rabbit_frame_sequencer;

  localparam int FB   = 184;
  localparam int TRIG = 50;
  localparam int TMO  = 400;
  localparam int MAXR = 3;
  localparam int HALF = 5;
  localparam int K_SILENT = 0, K_STALL = 1, K_GOOD = 2, K_BADPAR = 3;
`ifdef RABBIT_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_req = 1'b0;
  logic          sclk = 1'b0;
  logic          sdio = 1'b0;
  logic          trigger_out, busy, frame_valid, frame_error;
  logic [FB-1:0] frame_data;
  logic [1:0]    retry_count;

  always #10 clk = ~clk;

  rabbit_frame_sequencer #(
    .FRAME_BITS     (FB),
    .TRIG_CYCLES    (TRIG),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRY      (MAXR)
  ) dut (
    .fifty_MHz_int (clk),
    .reset_n       (rst_n),
    .start_req     (start_req),
    .SCLK_PE_3     (sclk),
    .SDIO_PE_5     (sdio),
    .trigger_out   (trigger_out),
    .busy          (busy),
    .frame_data    (frame_data),
    .frame_valid   (frame_valid),
    .frame_error   (frame_error),
    .retry_count   (retry_count)
  );

  typedef struct {
    bit            is_err;
    logic [FB-1:0] data;
    logic [1:0]    retry;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            passes = 0;
  int            trig_rises = 0;
  logic          trig_prev = 1'b0;
  logic [FB-1:0] last_good = '0;

  task automatic check(input string name, input logic [FB-1:0] act, input logic [FB-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (trigger_out && !trig_prev) trig_rises++;
    trig_prev = trigger_out;
  end

  // Monitor: every completion pulse retires one expected outcome.
  always @(negedge clk) begin
    if (rst_n && (frame_valid || frame_error)) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pulse: valid=%0b error=%0b with empty scoreboard", frame_valid, frame_error);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("outcome_is_error", FB'(frame_error), FB'(e.is_err));
        check("outcome_is_valid", FB'(frame_valid), FB'(!e.is_err));
        check("frame_data", frame_data, e.data);
        check("retry_count", FB'(retry_count), FB'(e.retry));
        check("busy_at_exit", FB'(busy), '0);
      end
    end
  end

  // Reference model: first attempt that delivers a complete acceptable frame wins.
  function automatic exp_t predict(input int kind[4], input logic [FB-1:0] fr[4],
                                   input logic [FB-1:0] prev, output int n_att);
    exp_t e;
    bit   complete;
    e.is_err = 1'b1;
    e.data   = prev;
    e.retry  = 2'(MAXR);
    n_att    = MAXR + 1;
    for (int a = 0; a <= MAXR; a++) begin
      complete = (kind[a] == K_GOOD) || (kind[a] == K_BADPAR);
      if (complete && (!PAR_EN || ((^fr[a]) == 1'b0))) begin
        e.is_err = 1'b0;
        e.data   = fr[a];
        e.retry  = 2'(a);
        n_att    = a + 1;
        return e;
      end
    end
    return e;
  endfunction

  function automatic logic [FB-1:0] rand_frame(input bit good_par);
    logic [FB-1:0] f;
    for (int i = 0; i < FB; i++) f[i] = 1'($urandom_range(0, 1));
    f[0] = 1'b0;
    if (^f) f[0] = 1'b1;
    if (!good_par) f[0] = ~f[0];
    return f;
  endfunction

  task automatic send_bits(input logic [FB-1:0] f, input int n, input int start_at);
    for (int i = 0; i < n; i++) begin
      sdio = f[FB-1-i];
      sclk = 1'b0;
      if (i == start_at) start_req = 1'b1;
      @(negedge clk);
      start_req = 1'b0;
      repeat (HALF - 1) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    sclk = 1'b0;
  endtask

  task automatic await_trigger(output bit ok);
    int n = 0;
    int w = 0;
    ok = 1'b0;
    while (!trigger_out && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (trigger_out) begin
      passes++;
      ok = 1'b1;
    end else begin
      $display("FAIL trigger_seen: none within %0d cycles", n);
    end
    if (ok) begin
      while (trigger_out && w < 1000) begin
        @(negedge clk);
        w++;
      end
      check("trigger_width", FB'(w), FB'(TRIG));
    end
  endtask

  task automatic run_request(input int kind[4], input logic [FB-1:0] fr[4],
                             input int stall[4], input int ignore_at);
    exp_t e;
    int   n_att, base, n;
    bit   ok;
    e = predict(kind, fr, last_good, n_att);
    if (!e.is_err) last_good = e.data;
    exp_q.push_back(e);
    base = trig_rises;
    @(negedge clk) start_req = 1'b1;
    @(negedge clk) start_req = 1'b0;
    check("busy_after_start", FB'(busy), FB'(1));
    for (int a = 0; a < n_att; a++) begin
      await_trigger(ok);
      if (!ok) break;
      repeat (3) @(negedge clk);
      case (kind[a])
        K_STALL:         send_bits(fr[a], stall[a], -1);
        K_GOOD, K_BADPAR: send_bits(fr[a], FB, (a == 0) ? ignore_at : -1);
        default: ;
      endcase
    end
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("busy_released", FB'(busy), '0);
    repeat (5) @(negedge clk);
    check("trigger_count", FB'(trig_rises - base), FB'(n_att));
  endtask

  initial begin
    int            kind[4];
    int            stall[4];
    logic [FB-1:0] fr[4];
    logic [FB-1:0] a5;
    int            base, n;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_trigger", FB'(trigger_out), '0);
    check("rst_busy", FB'(busy), '0);
    check("rst_valid", FB'(frame_valid), '0);
    check("rst_error", FB'(frame_error), '0);
    check("rst_frame_data", frame_data, '0);
    check("rst_retry", FB'(retry_count), '0);

    a5 = '0;
    for (int i = 0; i < FB / 8; i++) a5 = (a5 << 8) | FB'(8'hA5);
    for (int i = 0; i < 4; i++) begin
      kind[i] = K_SILENT; stall[i] = 0; fr[i] = '0;
    end

    // Basic frame, with a start_req pulsed mid-transfer that must be ignored.
    kind[0] = K_GOOD; fr[0] = a5;
    run_request(kind, fr, stall, 50);
    base = trig_rises;
    repeat (200) @(negedge clk);
    check("no_queued_start", FB'(trig_rises - base), '0);

    // Timeout on the first attempt, good frame on the second.
    kind[0] = K_SILENT; kind[1] = K_GOOD; fr[1] = rand_frame(1'b1);
    run_request(kind, fr, stall, -1);

    // No SCLK at all: four attempts, error, frame_data retained.
    kind[0] = K_SILENT; kind[1] = K_SILENT; kind[2] = K_SILENT; kind[3] = K_SILENT;
    run_request(kind, fr, stall, -1);

    // Stall after 100 bits, then a full frame with no stale bits.
    kind[0] = K_STALL; stall[0] = 100; fr[0] = {FB{1'b1}};
    kind[1] = K_GOOD;  fr[1] = rand_frame(1'b1);
    run_request(kind, fr, stall, -1);

    // Bad parity first, good second.
    kind[0] = K_BADPAR; fr[0] = rand_frame(1'b0);
    kind[1] = K_GOOD;   fr[1] = rand_frame(1'b1);
    kind[2] = K_SILENT; kind[3] = K_SILENT;
    run_request(kind, fr, stall, -1);

    for (int r = 0; r < 5; r++) begin
      for (int a = 0; a < 4; a++) begin
        kind[a]  = int'($urandom_range(0, 3));
        stall[a] = int'($urandom_range(1, FB - 1));
        fr[a]    = rand_frame(kind[a] != K_BADPAR);
      end
      run_request(kind, fr, stall, -1);
    end

    // Asynchronous reset at bit 90 of a transfer.
    @(negedge clk) start_req = 1'b1;
    @(negedge clk) start_req = 1'b0;
    n = 0;
    while (!trigger_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (trigger_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    send_bits(rand_frame(1'b1), 90, -1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_trigger", FB'(trigger_out), '0);
    check("mid_rst_busy", FB'(busy), '0);
    check("mid_rst_valid", FB'(frame_valid), '0);
    check("mid_rst_error", FB'(frame_error), '0);
    check("mid_rst_frame_data", frame_data, '0);
    check("mid_rst_retry", FB'(retry_count), '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_good = '0;

    kind[0] = K_GOOD; fr[0] = rand_frame(1'b1);
    for (int i = 1; i < 4; i++) kind[i] = K_SILENT;
    run_request(kind, fr, stall, -1);

    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", FB'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rabbit_frame_sequencer.md
Name: rabbit_frame_sequencer

Overview:
- Sequences one Rabbit-to-FPGA transfer of a 184-bit DDS control word, running on the 50 MHz board clock.
- On a start request it pulses trigger_out to the Rabbit, then samples the SCLK_PE_3/SDIO_PE_5 serial stream into a frame register. It counts bits and enforces timeouts, and retries on failure.
- Delivers a latched frame with a one-cycle valid pulse to the downstream converter. It replaces free-running capture with a controlled, self-checking handshake.

Parameters:
- FRAME_BITS, 184, bits per frame.
- TRIG_CYCLES, 50, trigger_out high time in clocks (1 us).
- TIMEOUT_CYCLES, 500000, max clocks from trigger end to first SCLK rise, and max clocks between consecutive SCLK rises (10 ms).
- MAX_RETRY, 3, retries after the first attempt before declaring failure.

Ports:
- fifty_MHz_int  in  1  50 MHz system clock.
- reset_n  in  1  async active-low reset.
- start_req  in  1  single-cycle request for one frame; ignored while busy.
- SCLK_PE_3  in  1  Rabbit serial clock, asynchronous.
- SDIO_PE_5  in  1  Rabbit serial data, asynchronous, valid at SCLK rise.
- trigger_out  out  1  trigger pulse to Rabbit.
- busy  out  1  high from accepted start_req until DONE/FAIL exit.
- frame_data  out  FRAME_BITS  last good frame; first received bit at bit FRAME_BITS-1.
- frame_valid  out  1  one-cycle pulse when frame_data updates.
- frame_error  out  1  one-cycle pulse when all attempts fail.
- retry_count  out  2  attempts consumed in the current or last request.

Behaviour:
- Reset values:
  - trigger_out=0, busy=0, frame_valid=0, frame_error=0.
  - frame_data=0, retry_count=0; state=IDLE.
  - Shift register and bit counter are cleared.
- Input sync: SCLK and SDIO each go through two flops; rise = sync1 & ~sync2_d. SDIO is taken from the same sync stage, so it is sample-aligned. Capture latency is 3 clocks after the pad edge. SCLK must have a period of at least 8 clocks.
- States:
  - IDLE: on start_req go to TRIG; busy=1; retry_count=0.
  - TRIG: trigger_out=1 for exactly TRIG_CYCLES clocks, then go to WAIT_CLK.
  - WAIT_CLK: the timer counts. On the first SCLK rise, shift the bit in, set count=1, go to SHIFT. On timer == TIMEOUT_CYCLES-1 with no rise, go to RETRY.
  - SHIFT: each SCLK rise shifts the bit in MSB-first and restarts the timer. When count reaches FRAME_BITS, go to CHECK. An inter-bit timeout goes to RETRY.
  - CHECK: copy the shift register to frame_data, pulse frame_valid, go to IDLE, clear busy. This takes one clock.
  - RETRY: if retry_count == MAX_RETRY, pulse frame_error and go to IDLE; otherwise increment retry_count, clear the shifter and counter, and go to TRIG.
- SCLK rises arriving in IDLE, TRIG or RETRY are discarded.
- frame_data holds its value through failed attempts.
- start_req while busy is ignored and not queued.
- start_req in the same cycle as the CHECK/RETRY→IDLE exit is ignored.
- Timer is 19 bits and saturates; the bit counter is 8 bits.
- Async reset mid-transfer returns to IDLE immediately. A partial frame is discarded and frame_data is cleared.

Optional Feature:
- RABBIT_PARITY_EN:
  - Defined: the last bit (frame bit 0) is even parity over the whole frame. In CHECK, odd XOR over all FRAME_BITS bits goes to RETRY instead of updating; frame_data is not written.
  - Undefined: no parity check; every complete frame is accepted.

Decomposition:
- Shared package rabbit_pkg:
  - state enum.
  - FRAME_BITS, TRIG_CYCLES and TIMEOUT_CYCLES defaults.
  - Retry-count width constant.
- One sub-module, rabbit_serial_sync: the 2-flop synchronizers plus rise detect, outputting sclk_rise and sdio_s. It is reusable by other Rabbit-facing blocks.

Test Plan:
- Basic: start_req → trigger_out high exactly 50 clocks. Then 184 SCLK rises at 1 MHz with pattern 0xA5 repeated → frame_valid 1 pulse, frame_data = pattern, busy drops the same cycle, retry_count=0.
- Timeout retry: no SCLK after the first trigger, a good frame after the second → two trigger pulses, retry_count=1, one frame_valid.
- Full failure: no SCLK ever → 4 trigger pulses, one frame_error pulse, retry_count=3, frame_data unchanged from its prior value.
- Mid-frame stall: SCLK stops after 100 bits for more than 10 ms → RETRY, shifter cleared. A following full frame is captured correctly with no stale bits.
- Reset and ignore: assert reset_n=0 at bit 90 → all outputs at reset values within 1 clock. A start_req pulsed while busy has no effect on trigger count.
- RABBIT_PARITY_EN: a frame with a bad parity bit → retry. With the macro undefined, the same frame → frame_valid.
